id_issue_stage: RTL and testbench

Parametrised decode/issue stage for the 5-stage RV32I pipeline, sitting between the fetch/decode register and EX. It replaces the combinational decode stage plus separate ID/EX register:
- extracts register indices and immediates;
- forwards operands from N bypass sources, detects load-use hazards and stalls;
- resolves B/JAL/JALR in ID;
- holds the result in an internal one-entry ID/EX register under a valid/ready handshake.

---
 rtl/id_issue_stage.sv | 209 ++++++++++++++++++++
 tb/tb_id_issue_stage.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_stage.sv
// RV32I decode/issue stage: operand bypass, load-use stall,
// early branch resolution and a one-entry ID/EX register.
module id_issue_stage #(
  parameter int FWD_N    = 3,
  parameter bit BR_IN_ID = 1'b1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_pc,
  output logic [4:0]           rf_raddr1,
  output logic [4:0]           rf_raddr2,
  input  logic [31:0]          rf_rdata1,
  input  logic [31:0]          rf_rdata2,
  input  logic [FWD_N-1:0]     fwd_valid,
  input  logic [FWD_N-1:0]     fwd_pend,
  input  logic [5*FWD_N-1:0]   fwd_rd,
  input  logic [32*FWD_N-1:0]  fwd_data,
  input  logic                 flush,
  output logic                 br_valid,
  output logic [31:0]          br_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_instr,
  output logic [31:0]          out_rs1v,
  output logic [31:0]          out_rs2v,
  output logic [31:0]          out_imm,
  output logic [4:0]           out_rd,
  output logic                 load_use,
  output logic [31:0]          stall_cnt
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic [31:0] imm;
    logic [4:0]  rd;
  } ent_t;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_st, is_r;
  logic use1, use2, wr_rd;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign rd  = in_instr[11:7];

  assign is_lui   = (opc == OP_LUI);
  assign is_auipc = (opc == OP_AUIPC);
  assign is_jal   = (opc == OP_JAL);
  assign is_jalr  = (opc == OP_JALR);
  assign is_br    = (opc == OP_BR);
  assign is_st    = (opc == OP_ST);
  assign is_r     = (opc == OP_R);

  assign use1  = ~(is_lui | is_auipc | is_jal);
  assign use2  = is_r | is_st | is_br;
  assign wr_rd = ~(is_st | is_br);

  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25],
                  in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31],
                  in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  always_comb begin
    imm = imm_i;
    unique case (1'b1)
      is_r:             imm = '0;
      is_st:            imm = imm_s;
      is_br:            imm = imm_b;
      is_lui, is_auipc: imm = imm_u;
      is_jal:           imm = imm_j;
      default:          imm = imm_i;
    endcase
  end

  logic [31:0] rs1v, rs2v;
  logic        pend1, pend2;

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    rs1v  = rf_rdata1;
    rs2v  = rf_rdata2;
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = FWD_N - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_rd[5*i +: 5] == rs1) begin
        rs1v  = fwd_data[32*i +: 32];
        pend1 = fwd_pend[i];
      end
      if (fwd_valid[i] && fwd_rd[5*i +: 5] == rs2) begin
        rs2v  = fwd_data[32*i +: 32];
        pend2 = fwd_pend[i];
      end
    end
    if (rs1 == 5'd0) begin
      rs1v  = '0;
      pend1 = 1'b0;
    end
    if (rs2 == 5'd0) begin
      rs2v  = '0;
      pend2 = 1'b0;
    end
  end

  logic fire;

  assign load_use = in_valid & ((use1 & pend1) | (use2 & pend2));
  assign in_ready = ~load_use & ~flush & (~out_valid | out_ready);
  assign fire     = in_valid & in_ready;

  logic taken;

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      is_jal, is_jalr: taken = 1'b1;
      is_br: begin
        case (f3)
          3'b000:  taken = (rs1v == rs2v);
          3'b001:  taken = (rs1v != rs2v);
          3'b100:  taken = ($signed(rs1v) < $signed(rs2v));
          3'b101:  taken = ($signed(rs1v) >= $signed(rs2v));
          3'b110:  taken = (rs1v < rs2v);
          3'b111:  taken = (rs1v >= rs2v);
          default: taken = 1'b0;
        endcase
      end
      default: taken = 1'b0;
    endcase
  end

  assign br_valid  = BR_IN_ID & fire & taken;
  assign br_target = is_jalr ? ((rs1v + imm_i) & ~32'd1)
                             : (in_pc + imm);

  ent_t        ent_d, ent_q;
  logic        vld_d, vld_q;
  logic [31:0] cnt_d, cnt_q;

  always_comb begin
    vld_d = vld_q;
    ent_d = ent_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (fire) begin
      vld_d       = 1'b1;
      ent_d.pc    = in_pc;
      ent_d.instr = in_instr;
      ent_d.rs1v  = use1 ? rs1v : '0;
      ent_d.rs2v  = use2 ? rs2v : '0;
      ent_d.imm   = imm;
      ent_d.rd    = wr_rd ? rd : 5'd0;
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
    cnt_d = (load_use && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_q <= 1'b0;
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = vld_q;
  assign out_pc    = ent_q.pc;
  assign out_instr = ent_q.instr;
  assign out_rs1v  = ent_q.rs1v;
  assign out_rs2v  = ent_q.rs2v;
  assign out_imm   = ent_q.imm;
  assign out_rd    = ent_q.rd;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Scoreboard bench for id_issue_stage: directed cases plus
// randomized traffic against a spec-level reference model.
module tb_id_issue_stage;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1 = '0;
  logic [31:0] rf_rdata2 = '0;
  logic [2:0]  fwd_valid = '0;
  logic [2:0]  fwd_pend = '0;
  logic [14:0] fwd_rd = '0;
  logic [95:0] fwd_data = '0;
  logic        flush = 1'b0;
  logic        br_valid;
  logic [31:0] br_target;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc, out_instr, out_rs1v, out_rs2v, out_imm;
  logic [4:0]  out_rd;
  logic        load_use;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  id_issue_stage #(.FWD_N(3), .BR_IN_ID(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_pend(fwd_pend),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .flush(flush),
    .br_valid(br_valid), .br_target(br_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .out_rs1v(out_rs1v), .out_rs2v(out_rs2v),
    .out_imm(out_imm), .out_rd(out_rd),
    .load_use(load_use), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        u1;
    logic        u2;
  } exp_t;

  exp_t        q[$];
  exp_t        m_exp;
  logic        m_lu, m_ready, m_fire, m_br;
  logic [31:0] m_tgt;
  logic [31:0] m_cnt = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sel(input logic [4:0] rs,
                                      input logic [31:0] rf,
                                      output logic pend);
    pend = 1'b0;
    if (rs == 5'd0) return 32'd0;
    for (int i = 0; i < 3; i++)
      if (fwd_valid[i] && fwd_rd[5*i +: 5] == rs) begin
        pend = fwd_pend[i];
        return fwd_data[32*i +: 32];
      end
    return rf;
  endfunction

  task automatic model();
    logic [31:0] i, im, v1, v2;
    logic [6:0]  op;
    logic [2:0]  f;
    logic        u1, u2, wr, p1, p2, tk;
    i  = in_instr;
    op = i[6:0];
    f  = i[14:12];
    u1 = !(op inside {7'h37, 7'h17, 7'h6f});
    u2 = op inside {7'h33, 7'h23, 7'h63};
    wr = !(op inside {7'h23, 7'h63});
    case (op)
      7'h33:        im = 32'd0;
      7'h23:        im = {{20{i[31]}}, i[31:25], i[11:7]};
      7'h63:        im = {{19{i[31]}}, i[31], i[7], i[30:25],
                          i[11:8], 1'b0};
      7'h37, 7'h17: im = {i[31:12], 12'b0};
      7'h6f:        im = {{11{i[31]}}, i[31], i[19:12], i[20],
                          i[30:21], 1'b0};
      default:      im = {{20{i[31]}}, i[31:20]};
    endcase
    v1 = sel(i[19:15], rf_rdata1, p1);
    v2 = sel(i[24:20], rf_rdata2, p2);
    m_lu    = in_valid && ((u1 && p1) || (u2 && p2));
    m_ready = !m_lu && !flush && (q.size() == 0 || out_ready);
    m_fire  = in_valid && m_ready;
    tk = 1'b0;
    if (op == 7'h6f || op == 7'h67) tk = 1'b1;
    if (op == 7'h63)
      case (f)
        3'd0: tk = (v1 == v2);
        3'd1: tk = (v1 != v2);
        3'd4: tk = ($signed(v1) < $signed(v2));
        3'd5: tk = ($signed(v1) >= $signed(v2));
        3'd6: tk = (v1 < v2);
        3'd7: tk = (v1 >= v2);
        default: tk = 1'b0;
      endcase
    if (op == 7'h67)
      m_tgt = (v1 + {{20{i[31]}}, i[31:20]}) & 32'hFFFF_FFFE;
    else
      m_tgt = in_pc + im;
    m_br  = m_fire && tk;
    m_exp = '{pc: in_pc, instr: i, rs1v: v1, rs2v: v2, imm: im,
              rd: wr ? i[11:7] : 5'd0, u1: u1, u2: u2};
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    model();
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(m_ready));
    chk("load_use", 32'(load_use), 32'(m_lu));
    chk("br_valid", 32'(br_valid), 32'(m_br));
    if (m_br) chk("br_target", br_target, m_tgt);
    chk("rf_raddr1", 32'(rf_raddr1), 32'(in_instr[19:15]));
    chk("rf_raddr2", 32'(rf_raddr2), 32'(in_instr[24:20]));
    chk("stall_cnt", stall_cnt, m_cnt);
    #1;
    if (!resetn) begin
      q.delete();
      m_cnt = '0;
    end else begin
      if (m_fire) q.push_back(m_exp);
      if (m_lu && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    end
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    flush     = 1'b0;
    fwd_valid = '0;
    fwd_pend  = '0;
    out_ready = 1'b1;
    rf_rdata1 = '0;
    rf_rdata2 = '0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6f, 7'h67};
    logic [31:0] r;
    r        = $urandom;
    r[6:0]   = ops[$urandom_range(0, 8)];
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  // Monitor: consumes the held entry on every handshake or flush.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (out_valid && (out_ready || flush)) begin
          if (q.size() == 0) begin
            chk("spurious_out", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            if (!flush) begin
              chk("out_pc", out_pc, e.pc);
              chk("out_instr", out_instr, e.instr);
              chk("out_imm", out_imm, e.imm);
              chk("out_rd", 32'(out_rd), 32'(e.rd));
              if (e.u1) chk("out_rs1v", out_rs1v, e.rs1v);
              if (e.u2) chk("out_rs2v", out_rs2v, e.rs2v);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] t;
    idle();
    nxt(); cyc();
    nxt(); cyc();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_imm", out_imm, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    nxt(); resetn = 1'b1; cyc();

    // back-to-back ADDI
    nxt(); in_valid = 1'b1; in_pc = 32'h0;
    in_instr = {12'd5, 5'd0, 3'b000, 5'd1, 7'h13}; cyc();
    nxt(); in_pc = 32'h4;
    in_instr = {12'd7, 5'd0, 3'b000, 5'd2, 7'h13}; cyc();
    chk("addi1_valid", 32'(out_valid), 32'd1);
    chk("addi1_imm", out_imm, 32'd5);
    chk("addi1_rd", 32'(out_rd), 32'd1);
    nxt(); idle(); cyc();
    chk("addi2_valid", 32'(out_valid), 32'd1);
    chk("addi2_imm", out_imm, 32'd7);
    chk("addi2_rd", 32'(out_rd), 32'd2);

    // forwarding priority
    nxt(); in_valid = 1'b1; in_pc = 32'h8;
    in_instr  = {7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33};
    fwd_valid = 3'b111;
    fwd_rd    = {5'd2, 5'd1, 5'd1};
    fwd_data  = {32'd4, 32'd20, 32'd10};
    cyc();
    nxt(); idle(); cyc();
    chk("fwd_rs1v", out_rs1v, 32'd10);
    chk("fwd_rs2v", out_rs2v, 32'd4);

    // load-use: entry held, stall, bubble, then issue
    nxt(); in_valid = 1'b1; in_pc = 32'h10;
    in_instr = {12'd1, 5'd0, 3'b000, 5'd4, 7'h13}; cyc();
    nxt(); in_pc = 32'h14;
    in_instr  = {7'd0, 5'd5, 5'd5, 3'b000, 5'd6, 7'h33};
    fwd_valid = 3'b001; fwd_pend = 3'b001;
    fwd_rd    = {5'd0, 5'd0, 5'd5};
    cyc();
    chk("lu_load_use", 32'(load_use), 32'd1);
    chk("lu_in_ready", 32'(in_ready), 32'd0);
    nxt(); fwd_pend = 3'b000; fwd_data = {64'd0, 32'h55}; cyc();
    chk("lu_bubble", 32'(out_valid), 32'd0);
    chk("lu_stall_cnt", stall_cnt, 32'd1);
    nxt(); idle(); cyc();
    chk("lu_rs1v", out_rs1v, 32'h55);
    chk("lu_rs2v", out_rs2v, 32'h55);

    // branches
    nxt(); in_valid = 1'b1; in_pc = 32'h100;
    in_instr  = {1'b0, 6'b000001, 5'd2, 5'd1, 3'b000, 4'b0000,
                 1'b0, 7'h63};
    rf_rdata1 = 32'd3; rf_rdata2 = 32'd3; cyc();
    chk("beq_taken", 32'(br_valid), 32'd1);
    chk("beq_target", br_target, 32'h120);
    nxt(); rf_rdata2 = 32'd4; cyc();
    chk("beq_not_taken", 32'(br_valid), 32'd0);
    nxt(); in_instr = {12'd0, 5'd1, 3'b000, 5'd1, 7'h67};
    rf_rdata1 = 32'h201; cyc();
    chk("jalr_valid", 32'(br_valid), 32'd1);
    chk("jalr_target", br_target, 32'h200);
    nxt(); idle(); cyc();

    // backpressure then flush
    nxt(); in_valid = 1'b1; in_pc = 32'h300;
    in_instr = {12'd9, 5'd0, 3'b000, 5'd8, 7'h13}; cyc();
    for (int k = 0; k < 3; k++) begin
      nxt(); out_ready = 1'b0; in_pc = 32'h304;
      in_instr = {20'h00010, 5'd1, 7'h6f}; cyc();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_pc", out_pc, 32'h300);
      chk("bp_out_imm", out_imm, 32'd9);
    end
    nxt(); flush = 1'b1; cyc();
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_br_valid", 32'(br_valid), 32'd0);
    nxt(); idle(); cyc();
    chk("flush_out_valid", 32'(out_valid), 32'd0);

    // store stall, then LUI ignores its rs1 field
    nxt(); in_valid = 1'b1; in_pc = 32'h400;
    in_instr  = {7'd0, 5'd7, 5'd0, 3'b010, 5'd4, 7'h23};
    fwd_valid = 3'b001; fwd_pend = 3'b001;
    fwd_rd    = {5'd0, 5'd0, 5'd7}; cyc();
    chk("sw_load_use", 32'(load_use), 32'd1);
    nxt(); fwd_pend = 3'b000; fwd_data = {64'd0, 32'h77}; cyc();
    nxt(); idle(); cyc();
    chk("sw_out_rd", 32'(out_rd), 32'd0);
    chk("sw_out_imm", out_imm, 32'd4);
    chk("sw_rs2v", out_rs2v, 32'h77);
    nxt(); in_valid = 1'b1; in_pc = 32'h404;
    in_instr  = {12'h123, 5'd7, 3'b000, 5'd9, 7'h37};
    fwd_valid = 3'b001; fwd_pend = 3'b001;
    fwd_rd    = {5'd0, 5'd0, 5'd7}; cyc();
    chk("lui_no_stall", 32'(load_use), 32'd0);
    chk("lui_in_ready", 32'(in_ready), 32'd1);
    nxt(); idle(); cyc();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      nxt();
      in_valid  = ($urandom % 4) != 0;
      in_instr  = rand_instr();
      t         = $urandom;
      in_pc     = {t[31:2], 2'b00};
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      fwd_valid = 3'($urandom);
      fwd_pend  = (($urandom % 4) == 0) ? 3'($urandom) : 3'd0;
      for (int i = 0; i < 3; i++) begin
        fwd_rd[5*i +: 5]    = 5'($urandom_range(0, 7));
        fwd_data[32*i +: 32] = $urandom;
      end
      flush     = ($urandom % 16) == 0;
      out_ready = ($urandom % 4) != 0;
      cyc();
    end
    nxt(); idle(); cyc();

    // reset in the middle of a stall
    nxt(); in_valid = 1'b1; in_pc = 32'h500;
    in_instr = {12'd3, 5'd0, 3'b000, 5'd1, 7'h13}; cyc();
    nxt(); out_ready = 1'b0; in_pc = 32'h504;
    in_instr  = {7'd0, 5'd5, 5'd5, 3'b000, 5'd6, 7'h33};
    fwd_valid = 3'b001; fwd_pend = 3'b001;
    fwd_rd    = {5'd0, 5'd0, 5'd5}; cyc();
    chk("mid_load_use", 32'(load_use), 32'd1);
    nxt(); resetn = 1'b0; cyc();
    nxt(); resetn = 1'b1; idle(); cyc();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cnt", stall_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
